// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg -- shared definitions for the pipeline hazard controller.
//   REG_ADDR_W  : register-file address width
//   ZERO_REG    : hard-wired zero register (never a real dependency)
//   haz_state_e : controller state encoding
//   src_hit()   : one ID source operand matching the EX destination
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 4;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 4'h0;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLUSH     = 2'd1,
        MEM_WAIT  = 2'd2,
        SEND_WAIT = 2'd3
    } haz_state_e;

    // True when a source operand is actually read and names the EX destination.
    function automatic logic src_hit(input logic [REG_ADDR_W-1:0] src_addr,
                                     input logic                  src_used,
                                     input logic [REG_ADDR_W-1:0] dst_addr);
        return src_used & (src_addr == dst_addr);
    endfunction

endpackage

// File: rtl/hazard_ctrl_cmp.sv
// haz_cmp -- load-use comparator.
//   Inputs : ID source addresses/used flags, EX destination, EX write enable and load flag.
//   Output : load_use_o, high when the ID instruction reads the register being loaded in EX.
module haz_cmp
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_p0_addr_i,
    input  logic [REG_ADDR_W-1:0] id_p1_addr_i,
    input  logic                  id_p0_used_i,
    input  logic                  id_p1_used_i,
    input  logic [REG_ADDR_W-1:0] ex_dst_addr_i,
    input  logic                  ex_we_i,
    input  logic                  ex_mem_re_i,
    output logic                  load_use_o
);

    // Writes to the zero register carry no data, so they never create a hazard.
    assign load_use_o = ex_mem_re_i & ex_we_i & (ex_dst_addr_i != ZERO_REG) &
                        (src_hit(id_p0_addr_i, id_p0_used_i, ex_dst_addr_i) |
                         src_hit(id_p1_addr_i, id_p1_used_i, ex_dst_addr_i));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard / stall / flush controller.
//   Inputs : clk, rst_n (async, active low), ID source operands, EX destination/write/load,
//            mispredict, mem_busy, spart_full, ex_send.
//   Outputs: pc_hold, if_id_stall, id_ex_stall, id_ex_flush, ex_mem_stall, ex_kill
//            (combinational from state + inputs, forced low while rst_n=0),
//            stall_cycles (saturating count of pc_hold cycles).
//   Build option: define HAZ_STALL_CNT_EN to include the stall-cycle counter; otherwise
//            stall_cycles is tied to zero.
//   Priority (highest first): mem_busy, send-block, mispredict, load-use.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_p0_addr,
    input  logic [REG_ADDR_W-1:0] id_p1_addr,
    input  logic                  id_p0_used,
    input  logic                  id_p1_used,
    input  logic [REG_ADDR_W-1:0] ex_dst_addr,
    input  logic                  ex_we,
    input  logic                  ex_mem_re,
    input  logic                  mispredict,
    input  logic                  mem_busy,
    input  logic                  spart_full,
    input  logic                  ex_send,
    output logic                  pc_hold,
    output logic                  if_id_stall,
    output logic                  id_ex_stall,
    output logic                  id_ex_flush,
    output logic                  ex_mem_stall,
    output logic                  ex_kill,
    output logic [15:0]           stall_cycles
);

    haz_state_e state_q, state_d;
    logic       pend_flush_q, pend_flush_d;
    logic       load_use_s;
    logic       send_blk_s;
    logic       pc_hold_s, if_id_stall_s, id_ex_stall_s, id_ex_flush_s, ex_mem_stall_s, ex_kill_s;

    haz_cmp u_cmp (
        .id_p0_addr_i  (id_p0_addr),
        .id_p1_addr_i  (id_p1_addr),
        .id_p0_used_i  (id_p0_used),
        .id_p1_used_i  (id_p1_used),
        .ex_dst_addr_i (ex_dst_addr),
        .ex_we_i       (ex_we),
        .ex_mem_re_i   (ex_mem_re),
        .load_use_o    (load_use_s)
    );

    // The send stays in EX while blocked, so spart_full alone keeps SEND_WAIT alive.
    assign send_blk_s = spart_full & (ex_send | (state_q == SEND_WAIT));

    // Next-state, pending-flush and control-output decode.
    always_comb begin
        state_d        = state_q;
        pend_flush_d   = pend_flush_q;
        pc_hold_s      = 1'b0;
        if_id_stall_s  = 1'b0;
        id_ex_stall_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        ex_mem_stall_s = 1'b0;
        ex_kill_s      = 1'b0;
        if (mem_busy) begin
            pc_hold_s      = 1'b1;
            if_id_stall_s  = 1'b1;
            id_ex_stall_s  = 1'b1;
            ex_mem_stall_s = 1'b1;
            state_d        = MEM_WAIT;
            // A flush interrupted in FLUSH is still owed once the stall ends.
            if (mispredict || (state_q == FLUSH)) begin
                pend_flush_d = 1'b1;
            end else begin
                pend_flush_d = pend_flush_q;
            end
        end else begin
            case (state_q)
                MEM_WAIT, SEND_WAIT: begin
                    if (send_blk_s && (state_q == SEND_WAIT)) begin
                        pc_hold_s     = 1'b1;
                        if_id_stall_s = 1'b1;
                        id_ex_stall_s = 1'b1;
                        ex_kill_s     = 1'b1;
                        if (mispredict) begin
                            pend_flush_d = 1'b1;
                        end else begin
                            pend_flush_d = pend_flush_q;
                        end
                    end else begin
                        // Release cycle: all stalls drop, owed flush runs next.
                        state_d      = pend_flush_q ? FLUSH : RUN;
                        pend_flush_d = 1'b0;
                    end
                end
                FLUSH, RUN: begin
                    if (send_blk_s) begin
                        pc_hold_s     = 1'b1;
                        if_id_stall_s = 1'b1;
                        id_ex_stall_s = 1'b1;
                        ex_kill_s     = 1'b1;
                        state_d       = SEND_WAIT;
                        if (mispredict || (state_q == FLUSH)) begin
                            pend_flush_d = 1'b1;
                        end else begin
                            pend_flush_d = pend_flush_q;
                        end
                    end else if (state_q == FLUSH) begin
                        // Second flush cycle; ID holds wrong-path code so load-use is ignored.
                        id_ex_flush_s = 1'b1;
                        state_d       = RUN;
                    end else if (mispredict) begin
                        id_ex_flush_s = 1'b1;
                        state_d       = FLUSH;
                    end else if (load_use_s) begin
                        pc_hold_s     = 1'b1;
                        if_id_stall_s = 1'b1;
                        id_ex_flush_s = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d      = RUN;
                    pend_flush_d = 1'b0;
                end
            endcase
        end
    end

    // State and pending-flush registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pend_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_flush_q <= pend_flush_d;
        end
    end

    // Outputs are forced low while reset is asserted, whatever the inputs do.
    assign pc_hold      = rst_n & pc_hold_s;
    assign if_id_stall  = rst_n & if_id_stall_s;
    assign id_ex_stall  = rst_n & id_ex_stall_s;
    assign id_ex_flush  = rst_n & id_ex_flush_s;
    assign ex_mem_stall = rst_n & ex_mem_stall_s;
    assign ex_kill      = rst_n & ex_kill_s;

`ifdef HAZ_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating increment on every pc_hold cycle.
    always_comb begin
        if (pc_hold_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vectors with literal expectations,
// cross-checked every cycle against a rule-level behavioural model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  id_p0_addr, id_p1_addr, ex_dst_addr;
    logic        id_p0_used, id_p1_used, ex_we, ex_mem_re;
    logic        mispredict, mem_busy, spart_full, ex_send;
    logic        pc_hold, if_id_stall, id_ex_stall, id_ex_flush, ex_mem_stall, ex_kill;
    logic [15:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    // Model state: which wait the pipeline is in, flush owed now / later, stall count.
    bit          m_in_mem, m_in_send, m_flush_now, m_flush_later;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_p0_addr(id_p0_addr), .id_p1_addr(id_p1_addr),
        .id_p0_used(id_p0_used), .id_p1_used(id_p1_used),
        .ex_dst_addr(ex_dst_addr), .ex_we(ex_we), .ex_mem_re(ex_mem_re),
        .mispredict(mispredict), .mem_busy(mem_busy),
        .spart_full(spart_full), .ex_send(ex_send),
        .pc_hold(pc_hold), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall), .ex_kill(ex_kill),
        .stall_cycles(stall_cycles)
    );

    function automatic logic [5:0] outs();
        return {pc_hold, if_id_stall, id_ex_stall, id_ex_flush, ex_mem_stall, ex_kill};
    endfunction

    task automatic clear_inputs();
        id_p0_addr = 4'd0; id_p1_addr = 4'd0; ex_dst_addr = 4'd0;
        id_p0_used = 1'b0; id_p1_used = 1'b0; ex_we = 1'b0; ex_mem_re = 1'b0;
        mispredict = 1'b0; mem_busy = 1'b0; spart_full = 1'b0; ex_send = 1'b0;
    endtask

    task automatic model_reset();
        m_in_mem = 1'b0; m_in_send = 1'b0; m_flush_now = 1'b0; m_flush_later = 1'b0;
        m_cnt = 16'h0000;
    endtask

    // Called at posedge+1 with inputs already driven. Bit order of lit/exp:
    // {pc_hold, if_id_stall, id_ex_stall, id_ex_flush, ex_mem_stall, ex_kill}.
    task automatic step(input string nm, input bit use_lit, input logic [5:0] lit);
        logic [5:0] exp_o;
        bit lu, blocked;
        bit n_mem, n_send, n_now, n_later;
        #3;
        lu = ex_mem_re && ex_we && ex_dst_addr != 4'd0 &&
             ((id_p0_used && id_p0_addr == ex_dst_addr) || (id_p1_used && id_p1_addr == ex_dst_addr));
        blocked = spart_full && (ex_send || m_in_send);
        n_mem = 1'b0; n_send = 1'b0; n_now = 1'b0; n_later = m_flush_later;
        if (mem_busy) begin
            exp_o = 6'b111010; n_mem = 1'b1;
            n_later = m_flush_later || mispredict || m_flush_now;
        end else if (m_in_mem || (m_in_send && !blocked)) begin
            exp_o = 6'b000000; n_now = m_flush_later; n_later = 1'b0;
        end else if (blocked) begin
            exp_o = 6'b111001; n_send = 1'b1;
            n_later = m_flush_later || mispredict || m_flush_now;
        end else if (m_flush_now) begin
            exp_o = 6'b000100;
        end else if (mispredict) begin
            exp_o = 6'b000100; n_now = 1'b1;
        end else if (lu) begin
            exp_o = 6'b110100;
        end else begin
            exp_o = 6'b000000;
        end
        checks++;
        if (outs() !== exp_o) begin
            failures++;
            $display("FAIL %s model: outputs got %b want %b", nm, outs(), exp_o);
        end
        checks++;
        if (stall_cycles !== m_cnt) begin
            failures++;
            $display("FAIL %s stall_cycles: got %0d want %0d", nm, stall_cycles, m_cnt);
        end
        if (use_lit) begin
            checks++;
            if (outs() !== lit) begin
                failures++;
                $display("FAIL %s literal: outputs got %b want %b", nm, outs(), lit);
            end
        end
        @(posedge clk);
        m_in_mem = n_mem; m_in_send = n_send; m_flush_now = n_now; m_flush_later = n_later;
`ifdef HAZ_STALL_CNT_EN
        if (exp_o[5] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
        #1;
    endtask

    task automatic set_lu(input logic [3:0] dst, input logic [3:0] p1);
        ex_mem_re = 1'b1; ex_we = 1'b1; ex_dst_addr = dst;
        id_p1_addr = p1; id_p1_used = 1'b1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 1'b0;
        mem_busy = 1'b1;  // reset must override a live event
        #2;
        checks++;
        if (outs() !== 6'b000000 || stall_cycles !== 16'h0000) begin
            failures++;
            $display("FAIL reset: outputs got %b cnt %0d want 000000 cnt 0", outs(), stall_cycles);
        end
        clear_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("idle", 1'b1, 6'b000000);

        // Load-use on p1: one bubble, then clean.
        set_lu(4'd3, 4'd3);
        step("lu_p1", 1'b1, 6'b110100);
        clear_inputs();
        step("lu_after", 1'b1, 6'b000000);
        // Destination is the zero register.
        set_lu(4'd0, 4'd3);
        step("lu_dst0", 1'b1, 6'b000000);
        set_lu(4'd0, 4'd0);
        step("lu_dst0_p1_0", 1'b1, 6'b000000);
        // p0 match but not used, then used.
        clear_inputs();
        ex_mem_re = 1'b1; ex_we = 1'b1; ex_dst_addr = 4'd7; id_p0_addr = 4'd7;
        step("lu_p0_unused", 1'b1, 6'b000000);
        id_p0_used = 1'b1;
        step("lu_p0", 1'b1, 6'b110100);
        ex_we = 1'b0;
        step("lu_no_we", 1'b1, 6'b000000);
        clear_inputs();

        // Mispredict pulse: flush for exactly 2 cycles.
        mispredict = 1'b1;
        step("mp_c1", 1'b1, 6'b000100);
        mispredict = 1'b0;
        set_lu(4'd5, 4'd5);  // load-use in FLUSH is ignored
        step("mp_c2_flush", 1'b1, 6'b000100);
        clear_inputs();
        step("mp_c3", 1'b1, 6'b000000);

        // mem_busy 4 cycles with mispredict in cycle 2.
        mem_busy = 1'b1;
        step("mb_c1", 1'b1, 6'b111010);
        mispredict = 1'b1;
        step("mb_c2", 1'b1, 6'b111010);
        mispredict = 1'b0;
        step("mb_c3", 1'b1, 6'b111010);
        step("mb_c4", 1'b1, 6'b111010);
        mem_busy = 1'b0;
        step("mb_release", 1'b1, 6'b000000);
        step("mb_flush", 1'b1, 6'b000100);
        step("mb_run", 1'b1, 6'b000000);

        // Send blocked 3 cycles.
        ex_send = 1'b1; spart_full = 1'b1;
        for (int i = 0; i < 3; i++) step("send_blk", 1'b1, 6'b111001);
        ex_send = 1'b0; spart_full = 1'b0;
        step("send_release", 1'b1, 6'b000000);
        step("send_run", 1'b1, 6'b000000);

        // All events at once, then unwinding through every wait.
        mem_busy = 1'b1; ex_send = 1'b1; spart_full = 1'b1; mispredict = 1'b1;
        set_lu(4'd2, 4'd2);
        step("all_c1", 1'b1, 6'b111010);
        mem_busy = 1'b0; mispredict = 1'b0;
        step("all_mem_rel", 1'b1, 6'b000000);
        step("all_send", 1'b1, 6'b111001);
        clear_inputs();
        step("all_send_rel", 1'b1, 6'b000000);
        step("all_flush", 1'b1, 6'b000100);
        step("all_run", 1'b1, 6'b000000);

        // Reset mid-MEM_WAIT with a pending flush.
        mem_busy = 1'b1; mispredict = 1'b1;
        step("rmw_c1", 1'b1, 6'b111010);
        mispredict = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== 6'b000000 || stall_cycles !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid_wait: outputs got %b cnt %0d want 000000 cnt 0", outs(), stall_cycles);
        end
        model_reset();
        @(posedge clk); #1;
        mem_busy = 1'b0;
        rst_n = 1'b1;
        step("rmw_after1", 1'b1, 6'b000000);
        step("rmw_after2", 1'b1, 6'b000000);
        set_lu(4'd9, 4'd9);
        step("rmw_lu", 1'b1, 6'b110100);
        clear_inputs();
        step("end_idle", 1'b1, 6'b000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
